// File: rtl/config_pkg.sv
// config_pkg: minimal core configuration type; carried through pmp_csr_regs unchanged.
package config_pkg;
    typedef struct packed {
        logic [31:0] xlen;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

// File: rtl/pmp_csr_pkg.sv
// pmp_csr_pkg: CSR bases, clear FSM states and pmpcfg field offsets.
package pmp_csr_pkg;
    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
    localparam int R_BIT = 0;
    localparam int W_BIT = 1;
    localparam int X_BIT = 2;
    localparam int A_LSB = 3;
    localparam int L_BIT = 7;
    localparam logic [7:0] CFG_RSVD_MASK = ~(8'(1 << L_BIT) | 8'(3 << A_LSB) | 8'(1 << X_BIT)
                                           | 8'(1 << W_BIT) | 8'(1 << R_BIT));
endpackage

// File: rtl/riscv_pkg.sv
// riscv: PMP configuration types shared with the PMP checker.
package riscv;
    typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_addr_mode_t;
    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;
    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;
endpackage

// File: rtl/pmp_cfg_legalize.sv
// pmp_cfg_legalize: WARL/lock legalisation of one pmpcfg byte write.
module pmp_cfg_legalize
    import pmp_csr_pkg::*;
(
    input  logic [7:0] old_i,
    input  logic [7:0] new_i,
    output logic [7:0] cfg_o,
    output logic       sup_o
);
    always_comb begin
        sup_o = old_i[L_BIT];
        cfg_o = sup_o ? old_i : new_i & ~(CFG_RSVD_MASK | ({7'b0, !new_i[R_BIT]} << W_BIT));
    end
endmodule

// File: rtl/pmp_csr_regs.sv
// pmp_csr_regs: PMP cfg/addr CSR file with lock rules and bulk-clear sequencer.
// Define PMP_CSR_LOCK_CNT_EN to add lock_viol_cnt_o, a saturating count of lock-suppressed writes.
module pmp_csr_regs
    import pmp_csr_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  csr_req_i,
    input  logic                                  csr_we_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [XLEN-1:0]                       csr_wdata_i,
    output logic                                  csr_ready_o,
    output logic                                  csr_rvalid_o,
    output logic [XLEN-1:0]                       csr_rdata_o,
    output logic                                  csr_err_o,
    input  logic                                  clear_req_i,
    output logic                                  clear_busy_o,
    output logic [NR_ENTRIES:0][PMP_LEN-1:0]      conf_addr_o,
    output riscv::pmpcfg_t [NR_ENTRIES:0]         conf_o
`ifdef PMP_CSR_LOCK_CNT_EN
    ,
    output logic [15:0]                           lock_viol_cnt_o
`endif
);
    localparam int unsigned BPR = XLEN / 8;
    localparam int unsigned IW  = NR_ENTRIES > 1 ? $clog2(NR_ENTRIES) : 1;

    clr_state_e                         state_q, state_d;
    logic [IW-1:0]                      idx_q, idx_d;
    riscv::pmpcfg_t [NR_ENTRIES-1:0]    cfg_q, cfg_d, cfg_leg;
    logic [NR_ENTRIES-1:0][PMP_LEN-1:0] addr_q, addr_d;
    logic [NR_ENTRIES-1:0]              cfg_sup, cfg_hit, addr_lock;
    logic                               rvalid_q, rvalid_d, err_q, err_d;
    logic [XLEN-1:0]                    rdata_q, rdata_d;
    logic [3:0]                         n;
    logic                               acc, wr, cfg_ok, addr_ok;
    logic                               unused_cfg;

    assign unused_cfg  = ^CVA6Cfg;
    assign n           = csr_addr_i[3:0];
    assign cfg_ok      = csr_addr_i[11:4] == PMPCFG_BASE[11:4] && (XLEN == 32 || !n[0])
                         && 32'({n, 2'b00}) < NR_ENTRIES;
    assign addr_ok     = csr_addr_i[11:4] == PMPADDR_BASE[11:4] && 32'(n) < NR_ENTRIES;
    assign csr_ready_o = state_q == IDLE && !clear_req_i && !rst_i;
    assign acc         = csr_req_i && csr_ready_o;
    assign wr          = acc && csr_we_i;

    for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_ent
        pmp_cfg_legalize u_leg (
            .old_i (cfg_q[e]),
            .new_i (csr_wdata_i[8*(e%BPR) +: 8]),
            .cfg_o (cfg_leg[e]),
            .sup_o (cfg_sup[e])
        );
        assign cfg_hit[e] = cfg_ok && 32'({n, 2'b00}) / BPR == e / BPR;
        // A locked TOR entry also freezes the address below it
        if (e + 1 < NR_ENTRIES) begin : g_tor
            assign addr_lock[e] = cfg_q[e].locked
                                  || (cfg_q[e+1].locked && cfg_q[e+1].addr_mode == riscv::TOR);
        end else begin : g_last
            assign addr_lock[e] = cfg_q[e].locked;
        end
    end

    always_comb begin
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        rdata_d = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            if (wr && cfg_hit[e]) cfg_d[e] = cfg_leg[e];
            if (wr && addr_ok && n == 4'(e) && !addr_lock[e]) addr_d[e] = PMP_LEN'(csr_wdata_i);
            if (acc && cfg_hit[e]) rdata_d[8*(e%BPR) +: 8] = cfg_q[e];
            if (acc && addr_ok && n == 4'(e)) rdata_d = XLEN'(addr_q[e]);
        end
        if (state_q == CLEAR && !cfg_q[idx_q].locked) cfg_d[idx_q] = '0;
        if (state_q == CLEAR && !addr_lock[idx_q]) addr_d[idx_q] = '0;
        state_d  = state_q == IDLE  ? (clear_req_i ? CLEAR : IDLE)
                 : state_q == CLEAR ? (idx_q == IW'(NR_ENTRIES - 1) ? DONE : CLEAR) : IDLE;
        idx_d    = state_q == CLEAR ? idx_q + IW'(1) : '0;
        rvalid_d = acc;
        err_d    = acc && !(cfg_ok || addr_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cfg_q    <= '0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cfg_q    <= cfg_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef PMP_CSR_LOCK_CNT_EN
    logic        lock_hit;
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        lock_hit = 1'b0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            lock_hit |= wr && ((cfg_hit[e] && cfg_sup[e]) || (addr_ok && n == 4'(e) && addr_lock[e]));
        end
        cnt_d = cnt_q + 16'(lock_hit && cnt_q != 16'hFFFF);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign lock_viol_cnt_o = cnt_q;
`else
    logic unused_sup;
    assign unused_sup = ^cfg_sup;
`endif

    assign csr_rvalid_o = rvalid_q;
    assign csr_rdata_o  = rdata_q;
    assign csr_err_o    = err_q;
    assign clear_busy_o = state_q != IDLE;
    assign conf_addr_o  = {PMP_LEN'(0), addr_q};
    assign conf_o       = {8'h00, cfg_q};
endmodule
